// File: rtl/alu_pkg.sv
// Shared definitions for the serial ALU: function-select codes, mode values
// and the sequencer state type.
package alu_pkg;

  localparam logic [3:0] FN_XOR      = 4'b0110;
  localparam logic [3:0] FN_XNOR_ADD = 4'b1001;

  localparam logic MODE_LOGIC = 1'b1;
  localparam logic MODE_ARITH = 1'b0;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

endpackage

// File: rtl/alu_slice.sv
// Combinational DIGIT-bit slice of a 74181-style ALU with active-high carry.
// With SERIAL_ALU_OVF_EN defined it also exports the carry into its top bit.
module alu_slice
  import alu_pkg::*;
#(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic [3:0]       s,
  input  logic             m,
  input  logic             cin,
  output logic [DIGIT-1:0] f,
  output logic             cout
`ifdef SERIAL_ALU_OVF_EN
  ,
  output logic             c_msb
`endif
);

  logic [DIGIT-1:0] p;
  logic [DIGIT-1:0] g;
  logic [DIGIT:0]   c;

  // Every function is P + G (+cin) in arithmetic mode, or XNOR(P, G) in logic mode.
  assign p = a | (b & {DIGIT{s[0]}}) | (~b & {DIGIT{s[1]}});
  assign g = (a & b & {DIGIT{s[3]}}) | (a & ~b & {DIGIT{s[2]}});

  always_comb begin
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < DIGIT; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
  end

  always_comb begin
    f    = p ^ g ^ c[DIGIT-1:0];
    cout = c[DIGIT];
    if (m == MODE_LOGIC) begin
      f    = ~(p ^ g);
      cout = 1'b0;
    end
  end

`ifdef SERIAL_ALU_OVF_EN
  assign c_msb = (m == MODE_LOGIC) ? 1'b0 : c[DIGIT-1];
`endif

endmodule

// File: rtl/serial_alu.sv
// Digit-serial ALU: WIDTH-bit operation, DIGIT bits per clock, LSB first.
// Optional signed-overflow output enabled by defining SERIAL_ALU_OVF_EN.
module serial_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       s,
  input  logic             m,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero
`ifdef SERIAL_ALU_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NDIG  = WIDTH / DIGIT;
  localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NDIG - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       s_q, s_d;
  logic             m_q, m_d;
  logic             cout_q, cout_d;
  logic             zero_q, zero_d;
  logic             accept;
  logic [DIGIT-1:0] slice_f;
  logic             slice_cout;
`ifdef SERIAL_ALU_OVF_EN
  logic             slice_c_msb;
  logic             ovf_q, ovf_d;
`endif

  alu_slice #(.DIGIT(DIGIT)) u_slice (
    .a    (opa_q[DIGIT-1:0]),
    .b    (opb_q[DIGIT-1:0]),
    .s    (s_q),
    .m    (m_q),
    .cin  (carry_q),
    .f    (slice_f),
    .cout (slice_cout)
`ifdef SERIAL_ALU_OVF_EN
    ,
    .c_msb(slice_c_msb)
`endif
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    result_d = result_q;
    s_d      = s_q;
    m_d      = m_q;
    cout_d   = cout_q;
    zero_d   = zero_q;
    accept   = 1'b0;
`ifdef SERIAL_ALU_OVF_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      IDLE: accept = start;
      RUN: begin
        // Operands shift down so the slice always sees the current digit at the bottom.
        opa_d   = opa_q >> DIGIT;
        opb_d   = opb_q >> DIGIT;
        acc_d   = (acc_q >> DIGIT) | (WIDTH'(slice_f) << (WIDTH - DIGIT));
        carry_d = slice_cout;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          cnt_d    = '0;
          state_d  = DONE;
          result_d = acc_d;
          cout_d   = slice_cout;
          zero_d   = (acc_d == '0);
`ifdef SERIAL_ALU_OVF_EN
          ovf_d    = slice_c_msb ^ slice_cout;
`endif
        end
      end
      DONE: begin
        accept  = start;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      opa_d   = a;
      opb_d   = b;
      s_d     = s;
      m_d     = m;
      carry_d = cin;
      cnt_d   = '0;
      state_d = RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      opa_q    <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      s_q      <= '0;
      m_q      <= MODE_ARITH;
      cout_q   <= 1'b0;
      zero_q   <= 1'b1;
`ifdef SERIAL_ALU_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      s_q      <= s_d;
      m_q      <= m_d;
      cout_q   <= cout_d;
      zero_q   <= zero_d;
`ifdef SERIAL_ALU_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign busy   = (state_q == RUN);
  assign done   = (state_q == DONE);
  assign result = result_q;
  assign cout   = cout_q;
  assign zero   = zero_q;
`ifdef SERIAL_ALU_OVF_EN
  assign ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_serial_alu.sv
// Self-checking bench for serial_alu: an 8-bit/1-bit-digit instance and a
// 16-bit/4-bit-digit instance against a table-driven reference model.
module tb_serial_alu;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        start8 = 1'b0, m8 = 1'b0, cin8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [3:0]  s8 = '0;
  logic        busy8, done8, cout8, zero8;
  logic [7:0]  res8;

  logic        start16 = 1'b0, m16 = 1'b0, cin16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic [3:0]  s16 = '0;
  logic        busy16, done16, cout16, zero16;
  logic [15:0] res16;
`ifdef SERIAL_ALU_OVF_EN
  logic        ovf8, ovf16;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  serial_alu #(.WIDTH(8), .DIGIT(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .s(s8), .m(m8), .cin(cin8),
    .busy(busy8), .done(done8), .result(res8), .cout(cout8), .zero(zero8)
`ifdef SERIAL_ALU_OVF_EN
    , .ovf(ovf8)
`endif
  );

  serial_alu #(.WIDTH(16), .DIGIT(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16), .s(s16), .m(m16), .cin(cin16),
    .busy(busy16), .done(done16), .result(res16), .cout(cout16), .zero(zero16)
`ifdef SERIAL_ALU_OVF_EN
    , .ovf(ovf16)
`endif
  );

  // Reference: the 74181 function table written as (X + Y + cin) or a logic expression.
  function automatic void ref_alu(input int w, input logic [31:0] ia, input logic [31:0] ib,
                                  input logic [3:0] is, input logic im, input logic icin,
                                  output logic [31:0] r, output logic co, output logic ov);
    logic [31:0] mask, hmask, na, nb, x, y;
    logic [32:0] sum, low;
    mask  = (32'h1 << w) - 32'h1;
    hmask = mask >> 1;
    na    = ~ia & mask;
    nb    = ~ib & mask;
    x     = ia;
    y     = '0;
    co    = 1'b0;
    ov    = 1'b0;
    if (im) begin
      case (is)
        4'd0:  r = na;
        4'd1:  r = ~(ia | ib);
        4'd2:  r = na & ib;
        4'd3:  r = '0;
        4'd4:  r = ~(ia & ib);
        4'd5:  r = nb;
        4'd6:  r = ia ^ ib;
        4'd7:  r = ia & nb;
        4'd8:  r = na | ib;
        4'd9:  r = ~(ia ^ ib);
        4'd10: r = ib;
        4'd11: r = ia & ib;
        4'd12: r = '1;
        4'd13: r = ia | nb;
        4'd14: r = ia | ib;
        default: r = ia;
      endcase
      r = r & mask;
    end else begin
      case (is)
        4'd0:  begin x = ia;       y = '0;      end
        4'd1:  begin x = ia | ib;  y = '0;      end
        4'd2:  begin x = ia | nb;  y = '0;      end
        4'd3:  begin x = mask;     y = '0;      end
        4'd4:  begin x = ia;       y = ia & nb; end
        4'd5:  begin x = ia | ib;  y = ia & nb; end
        4'd6:  begin x = ia;       y = nb;      end
        4'd7:  begin x = ia & nb;  y = mask;    end
        4'd8:  begin x = ia;       y = ia & ib; end
        4'd9:  begin x = ia;       y = ib;      end
        4'd10: begin x = ia | nb;  y = ia & ib; end
        4'd11: begin x = ia & ib;  y = mask;    end
        4'd12: begin x = ia;       y = ia;      end
        4'd13: begin x = ia | ib;  y = ia;      end
        4'd14: begin x = ia | nb;  y = ia;      end
        default: begin x = ia;     y = mask;    end
      endcase
      sum = {1'b0, x} + {1'b0, y} + {32'h0, icin};
      low = {1'b0, x & hmask} + {1'b0, y & hmask} + {32'h0, icin};
      r   = sum[31:0] & mask;
      co  = sum[w];
      ov  = low[w-1] ^ co;
    end
  endfunction

  // Drives one operation, then scrambles the inputs and waits (bounded) for done.
  task automatic run_op(input bit wide, input logic [15:0] ia, input logic [15:0] ib,
                        input logic [3:0] is, input logic im, input logic icin,
                        output logic [15:0] r, output logic co, output logic z,
                        output logic ov, output int lat, output int nbusy);
    @(negedge clk);
    if (wide) begin
      a16 = ia; b16 = ib; s16 = is; m16 = im; cin16 = icin; start16 = 1'b1;
    end else begin
      a8 = ia[7:0]; b8 = ib[7:0]; s8 = is; m8 = im; cin8 = icin; start8 = 1'b1;
    end
    @(negedge clk);
    start8 = 1'b0; start16 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); s8 = 4'($urandom); m8 = 1'($urandom); cin8 = 1'($urandom);
    a16 = 16'($urandom); b16 = 16'($urandom); s16 = 4'($urandom); m16 = 1'($urandom); cin16 = 1'($urandom);
    lat = 1;
    nbusy = 0;
    while (!(wide ? done16 : done8) && lat < 40) begin
      nbusy += int'(wide ? busy16 : busy8);
      @(negedge clk);
      lat++;
    end
    r  = wide ? res16 : {8'h00, res8};
    co = wide ? cout16 : cout8;
    z  = wide ? zero16 : zero8;
`ifdef SERIAL_ALU_OVF_EN
    ov = wide ? ovf16 : ovf8;
`else
    ov = 1'b0;
`endif
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (busy8 !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b want=0", busy8); end
    total++; if (done8 !== 1'b0) begin bad++; $display("[TB] FAIL reset_done got=%b want=0", done8); end
    total++; if (res8 !== 8'h00) begin bad++; $display("[TB] FAIL reset_result got=%h want=00", res8); end
    total++; if (cout8 !== 1'b0) begin bad++; $display("[TB] FAIL reset_cout got=%b want=0", cout8); end
    total++; if (zero8 !== 1'b1) begin bad++; $display("[TB] FAIL reset_zero got=%b want=1", zero8); end
    total++; if (zero16 !== 1'b1) begin bad++; $display("[TB] FAIL reset_zero16 got=%b want=1", zero16); end
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [7:0]  va [6] = '{8'h3C, 8'hFF, 8'h05, 8'hA5, 8'hA5, 8'h7F};
    logic [7:0]  vb [6] = '{8'h0F, 8'h01, 8'h03, 8'h0F, 8'h0F, 8'h01};
    logic [3:0]  vs [6] = '{4'b1001, 4'b1001, 4'b0110, 4'b0110, 4'b1001, 4'b1001};
    logic        vm [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic        vc [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [7:0]  vr [6] = '{8'h4B, 8'h00, 8'h02, 8'hAA, 8'h55, 8'h80};
    logic        vco[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [15:0] r;
    logic        co, z, ov;
    int          lat, nb;
    for (int i = 0; i < 6; i++) begin
      run_op(1'b0, {8'h00, va[i]}, {8'h00, vb[i]}, vs[i], vm[i], vc[i], r, co, z, ov, lat, nb);
      total++; if (lat !== 9) begin bad++; $display("[TB] FAIL dir%0d_latency got=%0d want=9", i, lat); end
      total++; if (nb !== 8) begin bad++; $display("[TB] FAIL dir%0d_busy_cycles got=%0d want=8", i, nb); end
      total++; if (r[7:0] !== vr[i]) begin bad++; $display("[TB] FAIL dir%0d_result got=%h want=%h", i, r[7:0], vr[i]); end
      total++; if (co !== vco[i]) begin bad++; $display("[TB] FAIL dir%0d_cout got=%b want=%b", i, co, vco[i]); end
      total++; if (z !== (vr[i] == 8'h00)) begin bad++; $display("[TB] FAIL dir%0d_zero got=%b want=%b", i, z, vr[i] == 8'h00); end
`ifdef SERIAL_ALU_OVF_EN
      total++; if (ov !== (i == 5)) begin bad++; $display("[TB] FAIL dir%0d_ovf got=%b want=%b", i, ov, i == 5); end
`endif
      @(negedge clk);
      total++; if (done8 !== 1'b0) begin bad++; $display("[TB] FAIL dir%0d_done_pulse got=%b want=0", i, done8); end
      total++; if (res8 !== vr[i]) begin bad++; $display("[TB] FAIL dir%0d_hold got=%h want=%h", i, res8, vr[i]); end
    end
  endtask

  task automatic test_random(input bit wide, input int n);
    logic [31:0] er;
    logic        eco, eov, co, z, ov;
    logic [15:0] ta, tb, r;
    logic [3:0]  ts;
    logic        tm, tc;
    int          lat, nb, w;
    w = wide ? 16 : 8;
    for (int i = 0; i < n; i++) begin
      ta = 16'($urandom); tb = 16'($urandom); ts = 4'($urandom); tm = 1'($urandom); tc = 1'($urandom);
      if (!wide) begin ta[15:8] = 8'h00; tb[15:8] = 8'h00; end
      ref_alu(w, {16'h0, ta}, {16'h0, tb}, ts, tm, tc, er, eco, eov);
      run_op(wide, ta, tb, ts, tm, tc, r, co, z, ov, lat, nb);
      total++; if (lat !== (wide ? 5 : 9)) begin bad++; $display("[TB] FAIL rnd_w%0d_latency got=%0d want=%0d", w, lat, wide ? 5 : 9); end
      total++; if (r !== er[15:0]) begin bad++; $display("[TB] FAIL rnd_w%0d_result a=%h b=%h s=%h m=%b cin=%b got=%h want=%h", w, ta, tb, ts, tm, tc, r, er[15:0]); end
      total++; if (co !== eco) begin bad++; $display("[TB] FAIL rnd_w%0d_cout s=%h m=%b got=%b want=%b", w, ts, tm, co, eco); end
      total++; if (z !== (er == 32'h0)) begin bad++; $display("[TB] FAIL rnd_w%0d_zero got=%b want=%b", w, z, er == 32'h0); end
`ifdef SERIAL_ALU_OVF_EN
      total++; if (ov !== eov) begin bad++; $display("[TB] FAIL rnd_w%0d_ovf got=%b want=%b", w, ov, eov); end
`endif
    end
  endtask

  task automatic test_wide();
    logic [15:0] r;
    logic        co, z, ov;
    int          lat, nb;
    run_op(1'b1, 16'h1234, 16'h0FFF, 4'b1001, 1'b0, 1'b1, r, co, z, ov, lat, nb);
    total++; if (lat !== 5) begin bad++; $display("[TB] FAIL wide_latency got=%0d want=5", lat); end
    total++; if (nb !== 4) begin bad++; $display("[TB] FAIL wide_busy_cycles got=%0d want=4", nb); end
    total++; if (r !== 16'h2234) begin bad++; $display("[TB] FAIL wide_result got=%h want=2234", r); end
    total++; if (co !== 1'b0) begin bad++; $display("[TB] FAIL wide_cout got=%b want=0", co); end
    test_random(1'b1, 20);
  endtask

  task automatic test_ignore_start();
    int lat;
    @(negedge clk);
    a8 = 8'h3C; b8 = 8'h0F; s8 = 4'b1001; m8 = 1'b0; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    lat = 1;
    while (!done8 && lat < 40) begin
      if (lat == 3) begin
        a8 = 8'hFF; b8 = 8'hFF; s8 = 4'b0110; m8 = 1'b1; cin8 = 1'b1; start8 = 1'b1;
      end else begin
        start8 = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start8 = 1'b0;
    total++; if (lat !== 9) begin bad++; $display("[TB] FAIL ignore_latency got=%0d want=9", lat); end
    total++; if (res8 !== 8'h4B) begin bad++; $display("[TB] FAIL ignore_result got=%h want=4B", res8); end
    @(negedge clk);
    total++; if (busy8 !== 1'b0) begin bad++; $display("[TB] FAIL ignore_no_restart got=%b want=0", busy8); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] e1, e2;
    logic        c1, c2, o1, o2;
    logic [7:0]  a1, b1, a2, b2;
    int          lat;
    a1 = 8'($urandom); b1 = 8'($urandom); a2 = 8'($urandom); b2 = 8'($urandom);
    ref_alu(8, {24'h0, a1}, {24'h0, b1}, 4'b1001, 1'b0, 1'b1, e1, c1, o1);
    ref_alu(8, {24'h0, a2}, {24'h0, b2}, 4'b0110, 1'b0, 1'b0, e2, c2, o2);
    @(negedge clk);
    a8 = a1; b8 = b1; s8 = 4'b1001; m8 = 1'b0; cin8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    a8 = a2; b8 = b2; s8 = 4'b0110; m8 = 1'b0; cin8 = 1'b0;
    lat = 1;
    while (!done8 && lat < 40) begin @(negedge clk); lat++; end
    total++; if (lat !== 9) begin bad++; $display("[TB] FAIL b2b_first_latency got=%0d want=9", lat); end
    total++; if (res8 !== e1[7:0]) begin bad++; $display("[TB] FAIL b2b_first_result got=%h want=%h", res8, e1[7:0]); end
    total++; if (cout8 !== c1) begin bad++; $display("[TB] FAIL b2b_first_cout got=%b want=%b", cout8, c1); end
    @(negedge clk);
    start8 = 1'b0;
    total++; if (busy8 !== 1'b1) begin bad++; $display("[TB] FAIL b2b_no_idle got=%b want=1", busy8); end
    lat = 1;
    while (!done8 && lat < 40) begin @(negedge clk); lat++; end
    total++; if (lat !== 9) begin bad++; $display("[TB] FAIL b2b_second_latency got=%0d want=9", lat); end
    total++; if (res8 !== e2[7:0]) begin bad++; $display("[TB] FAIL b2b_second_result got=%h want=%h", res8, e2[7:0]); end
    total++; if (cout8 !== c2) begin bad++; $display("[TB] FAIL b2b_second_cout got=%b want=%b", cout8, c2); end
  endtask

  task automatic test_mid_reset();
    logic [31:0] er;
    logic        eco, eov, co, z, ov;
    logic [15:0] r;
    int          lat, nb;
    run_op(1'b0, 16'h003C, 16'h000F, 4'b1001, 1'b0, 1'b0, r, co, z, ov, lat, nb);
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'h01; s8 = 4'b1001; m8 = 1'b0; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if (busy8 !== 1'b0) begin bad++; $display("[TB] FAIL midrst_busy got=%b want=0", busy8); end
    total++; if (done8 !== 1'b0) begin bad++; $display("[TB] FAIL midrst_done got=%b want=0", done8); end
    total++; if (res8 !== 8'h00) begin bad++; $display("[TB] FAIL midrst_result got=%h want=00", res8); end
    total++; if (zero8 !== 1'b1) begin bad++; $display("[TB] FAIL midrst_zero got=%b want=1", zero8); end
    total++; if (cout8 !== 1'b0) begin bad++; $display("[TB] FAIL midrst_cout got=%b want=0", cout8); end
    @(negedge clk);
    rst_n = 1'b1;
    ref_alu(8, 32'h5A, 32'h33, 4'b0110, 1'b0, 1'b1, er, eco, eov);
    run_op(1'b0, 16'h005A, 16'h0033, 4'b0110, 1'b0, 1'b1, r, co, z, ov, lat, nb);
    total++; if (lat !== 9) begin bad++; $display("[TB] FAIL midrst_fresh_latency got=%0d want=9", lat); end
    total++; if (r[7:0] !== er[7:0]) begin bad++; $display("[TB] FAIL midrst_fresh_result got=%h want=%h", r[7:0], er[7:0]); end
    total++; if (co !== eco) begin bad++; $display("[TB] FAIL midrst_fresh_cout got=%b want=%b", co, eco); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random(1'b0, 40);
    test_wide();
    test_ignore_start();
    test_back_to_back();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
